io_port_bank: RTL
=================

Name: io_port_bank

Overview:
- Peripheral-side counterpart of the processor's I/O interface.
- Services the processor's one-hot input requests (`req_in`) by supplying samples on `io_in`.
- Captures processor outputs flagged by the one-hot `out_en` into per-port buffers.
- Bridges each of NPORT ports to an external valid/ready stream, with a FIFO per port and direction, and sits directly beside the processor core at the top level.

Parameters:
- NUBITS, 31: data word width; matches the processor data path.
- NPORT, 4: number of input ports and number of output ports.
- DEPTH, 4: entries per FIFO; must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_in  in  NPORT  one-hot input request from the processor.
- io_in  out  NUBITS  signed data word to the processor.
- out_en  in  NPORT  one-hot output strobe from the processor.
- io_out  in  NUBITS  signed data word from the processor.
- ext_in_data  in  NPORT*NUBITS  external input words; port k occupies [k*NUBITS +: NUBITS].
- ext_in_valid  in  NPORT  external input word valid, per port.
- ext_in_ready  out  NPORT  input FIFO k not full.
- ext_out_data  out  NPORT*NUBITS  output FIFO heads, same packing as ext_in_data.
- ext_out_valid  out  NPORT  output FIFO k not empty.
- ext_out_ready  in  NPORT  external consumer accepts the head word.
- stat_clr  in  1  clears all sticky status bits.
- in_udf  out  NPORT  sticky: read of an empty input FIFO.
- out_ovf  out  NPORT  sticky: write to a full output FIFO; the word is dropped.
- sel_err  out  1  sticky: more than one bit set in req_in or in out_en.

Behaviour:
- Reset, synchronous on rst=1 at a clk edge:
  - All FIFOs empty; pointers and counts set to 0.
  - in_udf, out_ovf, sel_err = 0.
  - ext_out_valid = 0; ext_in_ready = all ones.
  - io_in = 0; held-last register = 0.
- Reset mid-transfer discards all buffered data. The rst cycle itself accepts no push or pop.

Input path (external to processor):
- Push to FIFO k when ext_in_valid[k] & ext_in_ready[k].
- ext_in_ready[k] = !full_k. It is combinational from the registered count, not from the same-cycle pop.
- io_in is combinational: the head of the FIFO selected by req_in. The processor samples it in the same cycle, so read latency is 0 cycles after the request.
- Pop FIFO k at the clock edge when req_in[k]=1 and FIFO k is non-empty.
- req_in[k]=1 with FIFO k empty:
  - io_in = 0 (see the optional feature for the alternative).
  - No pop occurs.
  - in_udf[k] is set.
  - A push arriving in the same cycle is still stored; there is no bypass.
- Simultaneous push and pop on a non-empty FIFO: both occur and the count is unchanged.
- req_in = 0: io_in = 0.

Output path (processor to external):
- out_en[k]=1 pushes io_out into output FIFO k at the edge.
- If FIFO k is full from its registered count, the word is dropped and out_ovf[k] is set. This holds even if ext_out_ready[k] pops in the same cycle.
- Pop when ext_out_valid[k] & ext_out_ready[k].
- ext_out_data slice k = the head register. It is stable while valid is high and not popped.

Select and status rules:
- Multi-hot req_in or out_en:
  - The lowest set index wins for data and for the push/pop.
  - sel_err is set.
- Sticky bits:
  - Set on their event.
  - Cleared by stat_clr at the edge.
  - If stat_clr and an event occur in the same cycle, the set wins.
- Pointers wrap modulo DEPTH. The count ranges 0..DEPTH, with full = (count==DEPTH).
- Data is stored and passed unmodified. It is signed two's complement and no width conversion is performed.

Optional Feature:
- Macro: IOB_HOLD_LAST_EN.
- Defined:
  - Each input port keeps a register of the last word popped.
  - An empty-FIFO read returns that register on io_in instead of 0.
  - in_udf is still set.
  - The register resets to 0.
- Undefined: an empty read returns 0 and no hold registers are built.

Test Plan:
1. Reset, then push 5, -7, 100 on input port 2. Assert req_in=4'b0100 for 3 cycles: io_in = 5, -7, 100 in the same cycles; FIFO 2 is empty afterwards; in_udf=0.
2. Push DEPTH=4 words into input port 0: ext_in_ready[0] drops to 0 after the 4th; a 5th word held on valid is not stored until a req_in[0] pop, then it is accepted the next cycle.
3. req_in[1] with input port 1 empty: io_in=0 and in_udf[1]=1 (with IOB_HOLD_LAST_EN: io_in = the last popped value, e.g. 42). stat_clr clears in_udf[1].
4. Pulse out_en[3] with io_out = 1, 2, 3, 4, 5 while ext_out_ready[3]=0: the FIFO holds 1..4 and out_ovf[3]=1. Raising ready yields ext_out_data slice 3 = 1, 2, 3, 4, then ext_out_valid[3]=0.
5. req_in=4'b0110 with both ports holding data: port 1 is popped, port 2 is untouched, sel_err=1.
6. Assert rst while FIFOs are partly full: next cycle all valid = 0, ready = 1, status = 0, io_in = 0.

Source files
------------

// File: rtl/io_port_bank_if.sv
// Processor-side and external-stream signals of io_port_bank.
// The master modport is the environment (processor plus external producers/consumers).
interface io_port_bank_if #(
    parameter int unsigned NUBITS = 31,
    parameter int unsigned NPORT  = 4
);
    // Processor side
    logic [NPORT-1:0]        req_in;
    logic signed [NUBITS-1:0] io_in;
    logic [NPORT-1:0]        out_en;
    logic signed [NUBITS-1:0] io_out;

    // External streams, port k at [k*NUBITS +: NUBITS]
    logic [NPORT*NUBITS-1:0] ext_in_data;
    logic [NPORT-1:0]        ext_in_valid;
    logic [NPORT-1:0]        ext_in_ready;
    logic [NPORT*NUBITS-1:0] ext_out_data;
    logic [NPORT-1:0]        ext_out_valid;
    logic [NPORT-1:0]        ext_out_ready;

    modport master (
        output req_in,
        input  io_in,
        output out_en,
        output io_out,
        output ext_in_data,
        output ext_in_valid,
        input  ext_in_ready,
        input  ext_out_data,
        input  ext_out_valid,
        output ext_out_ready
    );

    modport slave (
        input  req_in,
        output io_in,
        input  out_en,
        input  io_out,
        input  ext_in_data,
        input  ext_in_valid,
        output ext_in_ready,
        output ext_out_data,
        output ext_out_valid,
        input  ext_out_ready
    );
endinterface

// File: rtl/io_port_bank.sv
// Per-port input/output FIFOs bridging the processor's one-hot I/O strobes to valid/ready streams.
// Optional IOB_HOLD_LAST_EN: an empty input read returns the last word popped from that port.
module io_port_bank #(
    parameter int unsigned NUBITS = 31,
    parameter int unsigned NPORT  = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    io_port_bank_if.slave     bus,
    input  logic              stat_clr,
    output logic [NPORT-1:0]  in_udf,
    output logic [NPORT-1:0]  out_ovf,
    output logic              sel_err
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // Isolate the lowest set bit: multi-hot strobes resolve to the lowest index.
    function automatic logic [NPORT-1:0] lowest_one(input logic [NPORT-1:0] v);
        return v & (~v + NPORT'(1));
    endfunction

    function automatic logic multi_hot(input logic [NPORT-1:0] v);
        return |(v & (v - NPORT'(1)));
    endfunction

    logic [NPORT-1:0] req_sel;
    logic [NPORT-1:0] out_sel;

    logic [NPORT-1:0] in_empty;
    logic [NPORT-1:0] in_full;
    logic [NPORT-1:0] in_push;
    logic [NPORT-1:0] in_pop;
    logic signed [NUBITS-1:0] in_head [NPORT];
    logic signed [NUBITS-1:0] in_dry  [NPORT];

    logic [NPORT-1:0] out_empty;
    logic [NPORT-1:0] out_full;
    logic [NPORT-1:0] out_push;
    logic [NPORT-1:0] out_pop;

    logic [NPORT-1:0] udf_evt;
    logic [NPORT-1:0] ovf_evt;
    logic             sel_evt;

    logic [NPORT-1:0] in_udf_q;
    logic [NPORT-1:0] out_ovf_q;
    logic             sel_err_q;

    assign req_sel = lowest_one(bus.req_in);
    assign out_sel = lowest_one(bus.out_en);

    // Push/pop decisions use registered counts only; a same-cycle pop never frees a slot.
    assign in_push  = bus.ext_in_valid & ~in_full;
    assign in_pop   = req_sel & ~in_empty;
    assign out_push = out_sel & ~out_full;
    assign out_pop  = bus.ext_out_ready & ~out_empty;

    assign udf_evt = req_sel & in_empty;
    assign ovf_evt = out_sel & out_full;
    assign sel_evt = multi_hot(bus.req_in) | multi_hot(bus.out_en);

    assign bus.ext_in_ready  = ~in_full;
    assign bus.ext_out_valid = ~out_empty;

    for (genvar k = 0; k < NPORT; k++) begin : g_in
        logic signed [NUBITS-1:0] mem_q [DEPTH];
        logic [PW-1:0]            wptr_q;
        logic [PW-1:0]            rptr_q;
        logic [CW-1:0]            cnt_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (in_push[k]) begin
                    mem_q[wptr_q] <= bus.ext_in_data[k*NUBITS +: NUBITS];
                    wptr_q        <= wptr_q + PW'(1);
                end
                if (in_pop[k]) begin
                    rptr_q <= rptr_q + PW'(1);
                end
                case ({in_push[k], in_pop[k]})
                    2'b10:   cnt_q <= cnt_q + CW'(1);
                    2'b01:   cnt_q <= cnt_q - CW'(1);
                    default: cnt_q <= cnt_q;
                endcase
            end
        end

        assign in_empty[k] = (cnt_q == '0);
        assign in_full[k]  = (cnt_q == CW'(DEPTH));
        assign in_head[k]  = mem_q[rptr_q];

`ifdef IOB_HOLD_LAST_EN
        logic signed [NUBITS-1:0] hold_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                hold_q <= '0;
            end else if (in_pop[k]) begin
                hold_q <= mem_q[rptr_q];
            end
        end

        assign in_dry[k] = hold_q;
`else
        assign in_dry[k] = '0;
`endif
    end

    for (genvar k = 0; k < NPORT; k++) begin : g_out
        logic signed [NUBITS-1:0] mem_q [DEPTH];
        logic [PW-1:0]            wptr_q;
        logic [PW-1:0]            rptr_q;
        logic [CW-1:0]            cnt_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (out_push[k]) begin
                    mem_q[wptr_q] <= bus.io_out;
                    wptr_q        <= wptr_q + PW'(1);
                end
                if (out_pop[k]) begin
                    rptr_q <= rptr_q + PW'(1);
                end
                case ({out_push[k], out_pop[k]})
                    2'b10:   cnt_q <= cnt_q + CW'(1);
                    2'b01:   cnt_q <= cnt_q - CW'(1);
                    default: cnt_q <= cnt_q;
                endcase
            end
        end

        assign out_empty[k] = (cnt_q == '0);
        assign out_full[k]  = (cnt_q == CW'(DEPTH));
        assign bus.ext_out_data[k*NUBITS +: NUBITS] = mem_q[rptr_q];
    end

    // Zero-latency read: the processor samples io_in in the cycle it raises req_in.
    always_comb begin
        bus.io_in = '0;
        for (int k = 0; k < NPORT; k++) begin
            if (req_sel[k]) begin
                bus.io_in = in_empty[k] ? in_dry[k] : in_head[k];
            end
        end
    end

    // Sticky status: a same-cycle event beats stat_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_udf_q  <= '0;
            out_ovf_q <= '0;
            sel_err_q <= 1'b0;
        end else begin
            in_udf_q  <= (in_udf_q & ~{NPORT{stat_clr}}) | udf_evt;
            out_ovf_q <= (out_ovf_q & ~{NPORT{stat_clr}}) | ovf_evt;
            sel_err_q <= (sel_err_q & ~stat_clr) | sel_evt;
        end
    end

    assign in_udf  = in_udf_q;
    assign out_ovf = out_ovf_q;
    assign sel_err = sel_err_q;
endmodule
